// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dmem_pkg                                                  |
// | Desc   : Shared types, size codes and lane helpers for dmem_ctrl.  |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return ofs[0];
            SZ_W:    return (ofs != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            SZ_B:    return 4'b0001 << ofs;
            SZ_H:    return ofs[1] ? 4'b1100 : 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the right-aligned store data so every candidate lane sees it.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_B:    return {4{data[7:0]}};
            SZ_H:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] ofs, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ofs, 3'b000} +: 8];
        h = ofs[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    return {{24{~uns & b[7]}}, b};
            SZ_H:    return {{16{~uns & h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dmem_array                                                |
// | Desc   : DEPTH x 32 storage, byte write enables, async read.       |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module dmem_array #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] r_mem [DEPTH];

    // Contents are deliberately not reset so they survive a controller reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r_mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = r_mem[idx];

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dmem_ctrl                                                 |
// | Desc   : Data-memory controller with handshake, wait states and    |
// |          byte/half/word access with sign/zero-extended loads.      |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 0,
    parameter int AW       = $clog2(DEPTH) + 2
) (
    input  logic          clk,
    input  logic          rset,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic          rvalid,
    output logic [31:0]   rdata,
    output logic          err
);

    localparam logic [3:0] c_wait_load = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          w_commit;

    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_idle;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [1:0]    w_size;
    logic          w_uns;
    logic [31:0]   w_wdata;
    logic          w_mis;
    logic [3:0]    w_be;
    logic [31:0]   w_lanes;
    logic [31:0]   w_rword;

    assign w_idle = (r_state == IDLE);

    // With no wait states the commit happens on the acceptance edge itself,
    // so the live request fields are used while idle.
    assign w_we    = w_idle ? we    : r_we;
    assign w_addr  = w_idle ? addr  : r_addr;
    assign w_size  = w_idle ? size  : r_size;
    assign w_uns   = w_idle ? uns   : r_uns;
    assign w_wdata = w_idle ? wdata : r_wdata;

    assign w_mis   = misaligned(w_size, w_addr[1:0]);
    assign w_be    = (w_commit && w_we && !w_mis) ? lane_mask(w_size, w_addr[1:0]) : 4'b0000;
    assign w_lanes = store_lanes(w_size, w_wdata);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYC == 0) begin
                        w_state_nxt = RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_wait_load;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_size  <= SZ_B;
            r_uns   <= 1'b0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_idle && req) begin
                r_we    <= we;
                r_addr  <= addr;
                r_size  <= size;
                r_uns   <= uns;
                r_wdata <= wdata;
            end
            if (w_commit) begin
                r_rdata <= (w_mis || w_we) ? 32'd0 : load_extend(w_rword, w_size, w_addr[1:0], w_uns);
                r_err   <= w_mis;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .be    (w_be),
        .idx   (w_addr[AW-1:2]),
        .wdata (w_lanes),
        .rdata (w_rword)
    );

    assign ready  = w_idle;
    assign rvalid = (r_state == RESP);
    assign rdata  = r_rdata;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_dmem_ctrl                                              |
// | Desc   : Self-checking bench: zero-wait and 3-wait controllers.    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rset0, rset1, req0, req1;
    logic        we, uns;
    logic [9:0]  addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        ready0, rvalid0, err0, ready1, rvalid1, err1;
    logic [31:0] rdata0, rdata1;

    int n_cmp = 0;
    int n_bad = 0;

    // Byte-addressed reference images of both memories.
    logic [7:0] ref0 [1024];
    logic [7:0] ref1 [64];

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(256), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rset(rset0), .req(req0), .we(we), .addr(addr), .size(size),
        .uns(uns), .wdata(wdata), .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0)
    );

    dmem_ctrl #(.DEPTH(16), .WAIT_CYC(3)) u_dut1 (
        .clk(clk), .rset(rset1), .req(req1), .we(we), .addr(addr[5:0]), .size(size),
        .uns(uns), .wdata(wdata), .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .err(err1)
    );

    task automatic model_op(input int sel, input logic w, input logic [9:0] a, input logic [1:0] s,
                            input logic u, input logic [31:0] d, output logic [31:0] rd, output logic e);
        int     n;
        int     base;
        longint v;
        n    = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        base = int'(a);
        e    = (s == 2'd3) || (base % n != 0);
        rd   = 32'd0;
        if (!e) begin
            if (w) begin
                for (int k = 0; k < n; k++) begin
                    if (sel == 0) ref0[base + k] = d[8*k +: 8];
                    else          ref1[base + k] = d[8*k +: 8];
                end
            end else begin
                v = 0;
                for (int k = 0; k < n; k++)
                    v += longint'(sel == 0 ? ref0[base + k] : ref1[base + k]) << (8 * k);
                if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                    v -= longint'(1) << (8 * n);
                rd = v[31:0];
            end
        end
    endtask

    task automatic bus(input int sel, input logic w, input logic [9:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat);
        int n;
        @(negedge clk);
        we = w; addr = a; size = s; uns = u; wdata = d;
        if (sel == 0) req0 = 1'b1; else req1 = 1'b1;
        n = 0;
        while (!(sel == 0 ? ready0 : ready1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        lat = 1;
        while (!(sel == 0 ? rvalid0 : rvalid1) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!(sel == 0 ? rvalid0 : rvalid1)) lat = -1;
        rd = (sel == 0) ? rdata0 : rdata1;
        e  = (sel == 0) ? err0 : err1;
    endtask

    task automatic test_reset;
        n_cmp += 4;
        if (ready0 !== 1'b1)   begin n_bad++; $display("FAIL reset_ready0 got %b want 1", ready0); end
        if (rvalid0 !== 1'b0)  begin n_bad++; $display("FAIL reset_rvalid0 got %b want 0", rvalid0); end
        if (rdata0 !== 32'd0)  begin n_bad++; $display("FAIL reset_rdata0 got %h want 0", rdata0); end
        if (err0 !== 1'b0)     begin n_bad++; $display("FAIL reset_err0 got %b want 0", err0); end
        n_cmp += 2;
        if (ready1 !== 1'b1)   begin n_bad++; $display("FAIL reset_ready1 got %b want 1", ready1); end
        if (rvalid1 !== 1'b0)  begin n_bad++; $display("FAIL reset_rvalid1 got %b want 0", rvalid1); end
    endtask

    task automatic test_fill;
        logic [31:0] rd, exp_rd, d;
        logic        e, exp_e;
        int          lat;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            model_op(0, 1'b1, 10'(i * 4), 2'd2, 1'b0, d, exp_rd, exp_e);
            bus(0, 1'b1, 10'(i * 4), 2'd2, 1'b0, d, rd, e, lat);
            n_cmp++;
            if (lat !== 1 || e !== 1'b0) begin
                n_bad++;
                $display("FAIL fill0 idx %0d got lat %0d err %b want lat 1 err 0", i, lat, e);
            end
        end
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model_op(1, 1'b1, 10'(i * 4), 2'd2, 1'b0, d, exp_rd, exp_e);
            bus(1, 1'b1, 10'(i * 4), 2'd2, 1'b0, d, rd, e, lat);
            n_cmp++;
            if (lat !== 4) begin n_bad++; $display("FAIL fill1 idx %0d got lat %0d want 4", i, lat); end
        end
    endtask

    task automatic test_directed;
        logic [31:0] rd, exp_rd;
        logic        e, exp_e;
        int          lat;
        model_op(0, 1'b1, 10'h10, 2'd2, 1'b0, 32'hDEADBEEF, exp_rd, exp_e);
        bus(0, 1'b1, 10'h10, 2'd2, 1'b0, 32'hDEADBEEF, rd, e, lat);
        bus(0, 1'b0, 10'h10, 2'd2, 1'b0, 32'd0, rd, e, lat);
        n_cmp++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat !== 1) begin
            n_bad++; $display("FAIL word_load got %h err %b lat %0d want deadbeef err 0 lat 1", rd, e, lat);
        end
        model_op(0, 1'b1, 10'h11, 2'd0, 1'b0, 32'h80, exp_rd, exp_e);
        bus(0, 1'b1, 10'h11, 2'd0, 1'b0, 32'h80, rd, e, lat);
        bus(0, 1'b0, 10'h11, 2'd0, 1'b0, 32'd0, rd, e, lat);
        n_cmp++;
        if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_signed got %h want ffffff80", rd); end
        bus(0, 1'b0, 10'h11, 2'd0, 1'b1, 32'd0, rd, e, lat);
        n_cmp++;
        if (rd !== 32'h00000080) begin n_bad++; $display("FAIL lb_unsigned got %h want 00000080", rd); end
        bus(0, 1'b0, 10'h10, 2'd2, 1'b0, 32'd0, rd, e, lat);
        n_cmp++;
        if (rd !== 32'hDEAD80EF) begin n_bad++; $display("FAIL byte_merge got %h want dead80ef", rd); end
        model_op(0, 1'b1, 10'h10, 2'd2, 1'b0, 32'h80011234, exp_rd, exp_e);
        bus(0, 1'b1, 10'h10, 2'd2, 1'b0, 32'h80011234, rd, e, lat);
        bus(0, 1'b0, 10'h12, 2'd1, 1'b0, 32'd0, rd, e, lat);
        n_cmp++;
        if (rd !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_signed got %h want ffff8001", rd); end
        bus(0, 1'b1, 10'h22, 2'd2, 1'b0, 32'h12345678, rd, e, lat);
        n_cmp++;
        if (e !== 1'b1 || rd !== 32'd0) begin
            n_bad++; $display("FAIL misaligned_store got err %b rdata %h want err 1 rdata 0", e, rd);
        end
        model_op(0, 1'b0, 10'h20, 2'd2, 1'b0, 32'd0, exp_rd, exp_e);
        bus(0, 1'b0, 10'h20, 2'd2, 1'b0, 32'd0, rd, e, lat);
        n_cmp++;
        if (rd !== exp_rd || e !== 1'b0) begin
            n_bad++; $display("FAIL after_misaligned got %h err %b want %h err 0", rd, e, exp_rd);
        end
    endtask

    task automatic test_random(input int sel, input int count);
        logic [31:0] rd, exp_rd, d;
        logic [9:0]  a;
        logic [1:0]  s;
        logic        w, u, e, exp_e;
        int          lat, r;
        for (int i = 0; i < count; i++) begin
            r = int'($urandom_range(0, 9));
            s = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a = 10'($urandom) & ((sel == 0) ? 10'h3FF : 10'h03F);
            if ($urandom_range(0, 3) != 0)
                a = (s == 2'd1) ? (a & 10'h3FE) : (s == 2'd0) ? a : (a & 10'h3FC);
            w = 1'($urandom);
            u = 1'($urandom);
            d = $urandom;
            model_op(sel, w, a, s, u, d, exp_rd, exp_e);
            bus(sel, w, a, s, u, d, rd, e, lat);
            n_cmp++;
            if (rd !== exp_rd || e !== exp_e || lat !== ((sel == 0) ? 1 : 4)) begin
                n_bad++;
                $display("FAIL random%0d #%0d we %b a %h sz %0d uns %b got %h/%b/lat %0d want %h/%b",
                         sel, i, w, a, s, u, rd, e, lat, exp_rd, exp_e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_rd;
        logic        exp_e;
        int          hits;
        model_op(0, 1'b0, 10'h40, 2'd1, 1'b0, 32'd0, exp_rd, exp_e);
        @(negedge clk);
        we = 1'b0; addr = 10'h40; size = 2'd1; uns = 1'b0; req0 = 1'b1;
        hits = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rvalid0) begin
                hits++;
                n_cmp++;
                if (rdata0 !== exp_rd || ready0 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_data cyc %0d got %h ready %b want %h ready 0", c, rdata0, ready0, exp_rd);
                end
            end
        end
        req0 = 1'b0;
        n_cmp++;
        if (hits !== 10) begin n_bad++; $display("FAIL b2b_rate got %0d responses want 10", hits); end
    endtask

    task automatic test_wait_timing;
        logic [31:0] exp_rd, got_rd;
        logic        exp_e;
        logic [6:1]  rdy, rv;
        model_op(1, 1'b0, 10'h04, 2'd2, 1'b0, 32'd0, exp_rd, exp_e);
        @(negedge clk);
        we = 1'b0; addr = 10'h04; size = 2'd2; uns = 1'b0; req1 = 1'b1;
        n_cmp++;
        if (ready1 !== 1'b1) begin n_bad++; $display("FAIL wait_ready_pre got %b want 1", ready1); end
        got_rd = 32'd0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rdy[c] = ready1;
            rv[c]  = rvalid1;
            if (c == 4) begin
                got_rd = rdata1;
                req1   = 1'b0;
            end
        end
        n_cmp += 3;
        if (rdy !== 6'b110000) begin n_bad++; $display("FAIL wait_ready got %b want 110000", rdy); end
        if (rv !== 6'b001000)  begin n_bad++; $display("FAIL wait_rvalid got %b want 001000", rv); end
        if (got_rd !== exp_rd) begin n_bad++; $display("FAIL wait_rdata got %h want %h", got_rd, exp_rd); end
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] rd, exp_rd;
        logic        e, exp_e;
        int          lat, hits;
        @(negedge clk);
        we = 1'b1; addr = 10'h08; size = 2'd2; uns = 1'b0; wdata = ~{ref1[11], ref1[10], ref1[9], ref1[8]};
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        rset1 = 1'b0;
        #1;
        n_cmp += 2;
        if (ready1 !== 1'b1)  begin n_bad++; $display("FAIL rst_wait_ready got %b want 1", ready1); end
        if (rvalid1 !== 1'b0) begin n_bad++; $display("FAIL rst_wait_rvalid got %b want 0", rvalid1); end
        @(negedge clk);
        rset1 = 1'b1;
        hits = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rvalid1) hits++;
        end
        n_cmp++;
        if (hits !== 0) begin n_bad++; $display("FAIL rst_wait_no_resp got %0d responses want 0", hits); end
        model_op(1, 1'b0, 10'h08, 2'd2, 1'b0, 32'd0, exp_rd, exp_e);
        bus(1, 1'b0, 10'h08, 2'd2, 1'b0, 32'd0, rd, e, lat);
        n_cmp++;
        if (rd !== exp_rd || lat !== 4) begin
            n_bad++; $display("FAIL rst_wait_old got %h lat %0d want %h lat 4", rd, lat, exp_rd);
        end
    endtask

    initial begin
        rset0 = 1'b0; rset1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
        we = 1'b0; addr = '0; size = 2'd0; uns = 1'b0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        test_reset;
        rset0 = 1'b1; rset1 = 1'b1;
        test_fill;
        test_directed;
        test_random(0, 300);
        test_back_to_back;
        test_wait_timing;
        test_random(1, 60);
        test_reset_in_wait;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller that replaces the fixed single-cycle word memory on the core's load/store path. It adds a req/ready/rvalid handshake, a configurable number of wait states, and byte/halfword/word accesses with little-endian lane steering. Loads are sign- or zero-extended, and misaligned accesses are flagged. It sits between the core's memory stage and the storage array.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words. Must be a power of two.
- WAIT_CYC, 0, number of extra wait cycles between acceptance and response (0..15).
- AW, $clog2(DEPTH)+2, byte-address width. Derived; do not override.

Ports:
- clk  in  1  clock; rising edge active.
- rset  in  1  reset, asynchronous, active-low.
- req  in  1  access request.
- we  in  1  1 = store, 0 = load.
- addr  in  AW  byte address.
- size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as misaligned).
- uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- wdata  in  32  store data, right-aligned.
- ready  out  1  controller idle; a request is accepted when req && ready.
- rvalid  out  1  one-cycle response pulse, for loads and stores.
- rdata  out  32  extended load data. 0 for stores and errors.
- err  out  1  misaligned or reserved-size access; valid with rvalid.

## Operation
- State machine states: IDLE, WAIT, RESP.
- IDLE:
  - ready = 1.
  - On req: latch we, addr, size, uns, wdata.
  - If WAIT_CYC = 0, go to RESP; otherwise go to WAIT and load the wait counter with WAIT_CYC-1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, go to RESP.
- Commit (on the edge entering RESP):
  - Store: write the byte lanes selected by size and addr[1:0].
  - Load: register the extended read data.
- RESP:
  - rvalid = 1 for exactly one cycle, then return to IDLE.
  - ready = 0 in RESP and in WAIT.
- Misalignment rules:
  - Half access with addr[0] = 1 is misaligned.
  - Word access with addr[1:0] != 0 is misaligned.
  - size = 11 is always an error.
  - On an error: no write, rdata = 0, err = 1 in RESP.
- Store lanes: the byte goes to lane addr[1:0]; the half goes to lanes {addr[1],0}..{addr[1],1}. Other lanes are unchanged.
- Load extension: the selected byte or half is shifted to bit 0. The upper bits are filled with 0 if uns = 1, otherwise with the sign bit.
- Word index is addr[AW-1:2]. It always addresses a valid word (no out-of-range case).
- Reset during WAIT: the access is abandoned, no write occurs, and no rvalid is produced.
- Reset does not clear the array contents.
- req while ready = 0 is ignored. The requester must hold req until it is accepted.

## Timing
- Reset values: state = IDLE, ready = 1, rvalid = 0, rdata = 0, err = 0, wait counter = 0.
- Acceptance edge T0: rvalid is high during cycle T0+WAIT_CYC+1.
- ready rises again in the cycle after rvalid.
- Throughput: one access per WAIT_CYC+2 cycles.
- Read-after-write: a load accepted after a store's rvalid returns the new data.
- rdata and err are registered. They hold their values until the next RESP.

## Structure
- Package dmem_pkg:
  - size encodings SZ_B, SZ_H, SZ_W.
  - state enum IDLE/WAIT/RESP.
  - misalign-check and load-extend functions.
- Sub-module dmem_array: DEPTH x 32 storage with a 4-bit byte write-enable and combinational read. It holds no control logic.

## Test plan
- Reset, then store word 0xDEADBEEF at 0x10 with WAIT_CYC = 0, then load word from 0x10 → rvalid one cycle after each acceptance, rdata = 0xDEADBEEF, err = 0.
- Store byte 0x80 at 0x11, then load byte signed from 0x11 and load byte unsigned from 0x11 → 0xFFFFFF80 and 0x00000080. The word at 0x10 reads 0xDEAD80EF.
- Load half signed from 0x12 after word 0x8001_1234 is stored at 0x10 → rdata = 0xFFFF8001.
- Store word at 0x22 (misaligned), then load word from 0x20 → first response has err = 1 and rdata = 0; memory at 0x20 is unchanged.
- WAIT_CYC = 3 build: accept at T0 → ready low during T0+1..T0+4, rvalid at T0+4. req held during WAIT is not double-accepted.
- WAIT_CYC = 3: store accepted, rset pulled low at T0+2 → no rvalid, ready = 1 after reset, and a subsequent load shows the old value.
